// File: rtl/mine_pkg.sv
// Shared types, level table and LFSR taps for the minefield generator.
package mine_pkg;

    typedef enum logic [1:0] {
        EASY   = 2'd1,
        MEDIUM = 2'd2,
        HARD   = 2'd3
    } level_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PICK,
        CHECK,
        WRITE,
        DONE
    } state_t;

    localparam logic [4:0] DIM_EASY   = 5'd8;
    localparam logic [4:0] DIM_MED    = 5'd10;
    localparam logic [4:0] DIM_HARD   = 5'd16;
    localparam logic [5:0] MINES_EASY = 6'd10;
    localparam logic [5:0] MINES_MED  = 6'd20;
    localparam logic [5:0] MINES_HARD = 6'd40;

    // x^16 + x^14 + x^13 + x^11 in right-shift form: feedback is the XOR of
    // bits 0, 2, 3 and 5, shifted in at the MSB.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Level 0 is treated as easy.
    function automatic logic [4:0] level_dim(input logic [1:0] lvl);
        case (lvl)
            MEDIUM:  return DIM_MED;
            HARD:    return DIM_HARD;
            default: return DIM_EASY;
        endcase
    endfunction

    function automatic logic [5:0] level_mines(input logic [1:0] lvl);
        case (lvl)
            MEDIUM:  return MINES_MED;
            HARD:    return MINES_HARD;
            default: return MINES_EASY;
        endcase
    endfunction

endpackage

// File: rtl/mine_lfsr.sv
// 16-bit Fibonacci LFSR, loads SEED on reset, advances whenever en is high.
module mine_lfsr
    import mine_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] value
);

    // Shift right, feedback into bit 15.
    always_ff @(posedge clk) begin
        if (rst)
            value <= SEED;
        else if (en)
            value <= {^(value & LFSR_TAPS), value[15:1]};
    end

endmodule

// File: rtl/mine_place_ctrl.sv
// Minefield generator: clears the active board region, then writes the
// per-level number of mines at pseudo-random cells, never on the first click.
// Optional build macro MINE_SAFE_ZONE_EN also keeps the 3x3 neighbourhood of
// the first click free of mines.
module mine_place_ctrl
    import mine_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        level,
    input  logic [3:0]        first_x,
    input  logic [3:0]        first_y,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic [5:0]        mines_placed
);

    state_t      state, state_nxt;
    logic [1:0]  lvl_q;
    logic [3:0]  fx_q, fy_q;
    logic [3:0]  rx, ry;
    logic [7:0]  cand_q;
    logic [5:0]  mines_q;
    logic [15:0] lfsr;
    logic [7:0]  addr;

    logic [4:0]  dim;
    logic [5:0]  target;
    logic [5:0]  mines_inc;
    logic [3:0]  cx, cy;
    logic        out_of_dim;
    logic        on_first;
    logic        in_zone;
    logic        reject;
    logic        rx_last, ry_last;

    mine_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .value (lfsr)
    );

    assign dim        = level_dim(lvl_q);
    assign target     = level_mines(lvl_q);
    assign mines_inc  = mines_q + 6'd1;
    assign cx         = lfsr[3:0];
    assign cy         = lfsr[7:4];
    assign out_of_dim = ({1'b0, cx} >= dim) || ({1'b0, cy} >= dim);
    assign on_first   = (cx == fx_q) && (cy == fy_q);
    assign rx_last    = ({1'b0, rx} == dim - 5'd1);
    assign ry_last    = ({1'b0, ry} == dim - 5'd1);

`ifdef MINE_SAFE_ZONE_EN
    // Signed 6-bit distance to the first click; within one when -1, 0 or +1.
    logic [5:0] dx, dy;
    logic       near_x, near_y;
    assign dx      = {2'b00, cx} - {2'b00, fx_q};
    assign dy      = {2'b00, cy} - {2'b00, fy_q};
    assign near_x  = (dx == 6'h00) || (dx == 6'h01) || (dx == 6'h3F);
    assign near_y  = (dy == 6'h00) || (dy == 6'h01) || (dy == 6'h3F);
    assign in_zone = near_x && near_y;
`else
    assign in_zone = 1'b0;
`endif

    assign reject       = out_of_dim || on_first || in_zone;
    assign mem_addr     = ADDR_W'(addr);
    assign mines_placed = mines_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and RAM/handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        addr      = 8'h00;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                addr   = {ry, rx};
                if (rx_last && ry_last)
                    state_nxt = PICK;
            end
            PICK: begin
                busy = 1'b1;
                addr = lfsr[7:0];
                if (!reject)
                    state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                addr = cand_q;
                state_nxt = mem_rdata ? PICK : WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = 1'b1;
                addr      = cand_q;
                state_nxt = (mines_inc == target) ? DONE : PICK;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run context, raster walk, candidate latch and mine counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q   <= 2'd0;
            fx_q    <= 4'd0;
            fy_q    <= 4'd0;
            rx      <= 4'd0;
            ry      <= 4'd0;
            cand_q  <= 8'h00;
            mines_q <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lvl_q   <= level;
                        fx_q    <= first_x;
                        fy_q    <= first_y;
                        rx      <= 4'd0;
                        ry      <= 4'd0;
                        mines_q <= 6'd0;
                    end
                end
                CLEAR: begin
                    if (rx_last) begin
                        rx <= 4'd0;
                        ry <= ry + 4'd1;
                    end else begin
                        rx <= rx + 4'd1;
                    end
                end
                PICK: begin
                    if (!reject)
                        cand_q <= lfsr[7:0];
                end
                WRITE: mines_q <= mines_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mine_place_ctrl.sv
// Directed bench for mine_place_ctrl against a one-cycle-read board RAM model.
module tb_mine_place_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] level;
    logic [3:0] first_x, first_y;
    logic       busy, done, mem_we, mem_wdata, mem_rdata;
    logic [7:0] mem_addr;
    logic [5:0] mines_placed;

    logic       ram [0:255];
    int         clear_wr, mine_wr, over_wr, out_wr, done_cnt;
    logic [4:0] run_dim;
    int         n_vec, n_fail;

    mine_place_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .level        (level),
        .first_x      (first_x),
        .first_y      (first_y),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mines_placed (mines_placed)
    );

    always #5 clk = ~clk;

    // Board RAM model plus write/done bookkeeping.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (!rst && mem_we) begin
            if (mem_wdata) begin
                mine_wr++;
                if (ram[mem_addr]) over_wr++;
                if ({1'b0, mem_addr[3:0]} >= run_dim || {1'b0, mem_addr[7:4]} >= run_dim) out_wr++;
            end else begin
                clear_wr++;
            end
            ram[mem_addr] = mem_wdata;
        end
        if (!rst && done) done_cnt++;
    end

    task automatic preload(input logic v);
        for (int i = 0; i < 256; i++) ram[i] = v;
    endtask

    task automatic clear_stats(input logic [4:0] d);
        clear_wr = 0; mine_wr = 0; over_wr = 0; out_wr = 0; done_cnt = 0;
        run_dim = d;
    endtask

    task automatic pulse_start(input logic [1:0] l, input logic [3:0] x, input logic [3:0] y);
        level = l; first_x = x; first_y = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    function automatic int ones_in(input int d);
        int n = 0;
        for (int y = 0; y < d; y++)
            for (int x = 0; x < d; x++)
                if (ram[y*16 + x]) n++;
        return n;
    endfunction

    task automatic test_reset();
        preload(1'b0);
        clear_stats(5'd8);
        rst = 1'b1; start = 1'b0; level = 2'd0; first_x = 4'd0; first_y = 4'd0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_vec++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        n_vec++; if (mines_placed !== 6'd0) begin n_fail++; $display("FAIL reset_mines: got %0d want 0", mines_placed); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_easy();
        bit ok;
        int n;
        preload(1'b1);
        clear_stats(5'd8);
        pulse_start(2'd1, 4'd0, 4'd0);
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL easy_busy: got %b want 1", busy); end
        wait_done(20000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL easy_timeout: got no done want done"); end
        n = ones_in(8);
        n_vec++; if (clear_wr != 64) begin n_fail++; $display("FAIL easy_clears: got %0d want 64", clear_wr); end
        n_vec++; if (n != 10) begin n_fail++; $display("FAIL easy_ones: got %0d want 10", n); end
        n_vec++; if (out_wr != 0) begin n_fail++; $display("FAIL easy_outside: got %0d want 0", out_wr); end
        n_vec++; if (ram[0] !== 1'b0) begin n_fail++; $display("FAIL easy_first: got %b want 0", ram[0]); end
        n_vec++; if (mines_placed !== 6'd10) begin n_fail++; $display("FAIL easy_mines: got %0d want 10", mines_placed); end
        @(negedge clk);
        n_vec++; if (done_cnt != 1) begin n_fail++; $display("FAIL easy_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL easy_idle: got done=%b busy=%b want 0 0", done, busy); end
        n_vec++; if (mines_placed !== 6'd10) begin n_fail++; $display("FAIL easy_hold: got %0d want 10", mines_placed); end
    endtask

    task automatic test_hard();
        bit ok;
        int n;
        preload(1'b1);
        clear_stats(5'd16);
        pulse_start(2'd3, 4'd15, 4'd15);
        wait_done(20000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL hard_timeout: got no done want done"); end
        n = ones_in(16);
        n_vec++; if (clear_wr != 256) begin n_fail++; $display("FAIL hard_clears: got %0d want 256", clear_wr); end
        n_vec++; if (n != 40) begin n_fail++; $display("FAIL hard_ones: got %0d want 40", n); end
        n_vec++; if (mine_wr != 40) begin n_fail++; $display("FAIL hard_writes: got %0d want 40", mine_wr); end
        n_vec++; if (over_wr != 0) begin n_fail++; $display("FAIL hard_overwrite: got %0d want 0", over_wr); end
        n_vec++; if (ram[255] !== 1'b0) begin n_fail++; $display("FAIL hard_first: got %b want 0", ram[255]); end
        n_vec++; if (mines_placed !== 6'd40) begin n_fail++; $display("FAIL hard_mines: got %0d want 40", mines_placed); end
        @(negedge clk);
    endtask

    task automatic test_busy_abort();
        bit ok;
        bit seen;
        preload(1'b0);
        clear_stats(5'd8);
        pulse_start(2'd1, 4'd0, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (clear_wr == 64 && busy && !mem_we) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (!seen) begin n_fail++; $display("FAIL busy_reach_pick: got none want pick"); end
        level = 2'd3; first_x = 4'd3; first_y = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL busy_timeout: got no done want done"); end
        n_vec++; if (mines_placed !== 6'd10) begin n_fail++; $display("FAIL busy_target: got %0d want 10", mines_placed); end
        n_vec++; if (clear_wr != 64) begin n_fail++; $display("FAIL busy_clears: got %0d want 64", clear_wr); end
        n_vec++; if (ram[0] !== 1'b0) begin n_fail++; $display("FAIL busy_first: got %b want 0", ram[0]); end
        @(negedge clk);

        preload(1'b0);
        clear_stats(5'd16);
        pulse_start(2'd3, 4'd0, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (mem_we && mem_wdata) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (!seen) begin n_fail++; $display("FAIL abort_reach_write: got none want write"); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b we=%b want 0 0", busy, mem_we); end
        n_vec++; if (mines_placed !== 6'd0) begin n_fail++; $display("FAIL abort_mines: got %0d want 0", mines_placed); end
        rst = 1'b0;
        @(negedge clk);
        preload(1'b0);
        clear_stats(5'd8);
        pulse_start(2'd1, 4'd2, 4'd2);
        wait_done(20000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL abort_rerun_timeout: got no done want done"); end
        n_vec++; if (mines_placed !== 6'd10) begin n_fail++; $display("FAIL abort_rerun_mines: got %0d want 10", mines_placed); end
        n_vec++; if (clear_wr != 64) begin n_fail++; $display("FAIL abort_rerun_clears: got %0d want 64", clear_wr); end
        n_vec++; if (ram[8'h22] !== 1'b0) begin n_fail++; $display("FAIL abort_rerun_first: got %b want 0", ram[8'h22]); end
        @(negedge clk);
    endtask

    task automatic test_safe_zone();
        bit ok;
        int n;
        preload(1'b1);
        clear_stats(5'd10);
        pulse_start(2'd2, 4'd5, 4'd5);
        wait_done(20000, ok);
        n = ones_in(10);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL med_timeout: got no done want done"); end
        n_vec++; if (n != 20) begin n_fail++; $display("FAIL med_ones: got %0d want 20", n); end
        n_vec++; if (mines_placed !== 6'd20) begin n_fail++; $display("FAIL med_mines: got %0d want 20", mines_placed); end
        n_vec++; if (clear_wr != 100) begin n_fail++; $display("FAIL med_clears: got %0d want 100", clear_wr); end
        n_vec++; if (ram[8'h55] !== 1'b0) begin n_fail++; $display("FAIL med_first: got %b want 0", ram[8'h55]); end
`ifdef MINE_SAFE_ZONE_EN
        n = 0;
        for (int y = 4; y <= 6; y++)
            for (int x = 4; x <= 6; x++)
                if (ram[y*16 + x]) n++;
        n_vec++; if (n != 0) begin n_fail++; $display("FAIL med_zone: got %0d want 0", n); end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        preload(1'b0);
        clear_stats(5'd8);
        pulse_start(2'd1, 4'd0, 4'd0);
        wait_done(20000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL b2b_first_timeout: got no done want done"); end
        n_vec++; if (mines_placed !== 6'd10) begin n_fail++; $display("FAIL b2b_first_mines: got %0d want 10", mines_placed); end
        // start during the DONE cycle is dropped
        level = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_start: got busy=%b want 0", busy); end
        // start in the following IDLE cycle is taken
        preload(1'b0);
        clear_stats(5'd10);
        pulse_start(2'd2, 4'd9, 4'd0);
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
        n_vec++; if (mines_placed !== 6'd0) begin n_fail++; $display("FAIL b2b_cleared: got %0d want 0", mines_placed); end
        wait_done(20000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL b2b_second_timeout: got no done want done"); end
        n_vec++; if (mines_placed !== 6'd20) begin n_fail++; $display("FAIL b2b_second_mines: got %0d want 20", mines_placed); end
        n_vec++; if (clear_wr != 100) begin n_fail++; $display("FAIL b2b_clears: got %0d want 100", clear_wr); end
        n_vec++; if (ram[8'h09] !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got %b want 0", ram[8'h09]); end
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        test_reset();
        test_easy();
        test_hard();
        test_busy_abort();
        test_safe_zone();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
